// File: rtl/uart_tx_frame_if.sv
// Parallel-side and line-side signals of the UART transmitter.
// UART_TX_TWO_STOP_EN adds the STOP2 configuration input.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
`ifdef UART_TX_TWO_STOP_EN
  logic                  STOP2;
`endif
  logic                  TX_OUT;
  logic                  Busy;

`ifdef UART_TX_TWO_STOP_EN
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, STOP2,
                  input  TX_OUT, Busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale, STOP2,
                  output TX_OUT, Busy);
`else
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
                  input  TX_OUT, Busy);
  modport slave  (input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
                  output TX_OUT, Busy);
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; bit = Prescale clocks.
// UART_TX_TWO_STOP_EN adds STOP2 for an optional second stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (0)
// DATA   | data bit bit_idx_q, LSB first
// PARITY | parity of latched data
// STOP   | stop bit(s) (1); last cycle may accept the next word
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_frame_if.slave   bus
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            period_q, period_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
`endif

  logic last_cyc;
  logic stop_last;
  logic accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
`endif

    last_cyc = (cnt_q == (period_q - 6'd1));
`ifdef UART_TX_TWO_STOP_EN
    stop_last = last_cyc && (!stop2_q || stop_idx_q);
`else
    stop_last = last_cyc;
`endif
    accept = bus.Data_Valid && ((state_q == IDLE) || ((state_q == STOP) && stop_last));

    if (state_q != IDLE) begin
      cnt_d = last_cyc ? 6'd0 : (cnt_q + 6'd1);
    end

    case (state_q)
      START: begin
        if (last_cyc) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (last_cyc) begin
          if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
`ifdef UART_TX_TWO_STOP_EN
            stop_idx_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_cyc) begin
          state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
          stop_idx_d = 1'b0;
`endif
        end
      end
      STOP: begin
        if (stop_last) begin
          state_d = IDLE;
        end
`ifdef UART_TX_TWO_STOP_EN
        else if (last_cyc) begin
          stop_idx_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the STOP->IDLE transition for back-to-back frames.
    if (accept) begin
      state_d   = START;
      cnt_d     = '0;
      bit_idx_d = '0;
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
      period_d  = (bus.Prescale == 6'd0) ? 6'd1 : bus.Prescale;
`ifdef UART_TX_TWO_STOP_EN
      stop2_d    = bus.STOP2;
      stop_idx_d = 1'b0;
`endif
    end

    // Outputs are registered from the next state so the line never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
      PARITY:  tx_d = par_typ_d ? ~^data_d : ^data_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame.
// Define UART_TX_TWO_STOP_EN to also exercise the two-stop-bit option.
module tb_uart_tx_frame;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = ps;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  // Records the line and Busy for n cycles starting from the current cycle.
  task automatic capture(input int n, output logic [1023:0] ln, output logic [1023:0] bz);
    ln = '0;
    bz = '0;
    for (int i = 0; i < n; i++) begin
      ln[i] = bus.TX_OUT;
      bz[i] = bus.Busy;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [1023:0] ln, bz;
    logic [15:0]   exp;
    int            err;
    RST = 1'b1;
    tick();
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
    RST = 1'b0;
    tick();
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    exp = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    capture(88, ln, bz);
    err = -1;
    for (int i = 0; i < 88; i++)
      if (err < 0 && (ln[i] !== exp[i/8] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL frame_a5_even: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/8]);
    end
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_a5: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_parity_modes();
    logic [1023:0] ln, bz;
    logic [15:0]   exp;
    int            err;
    send(8'hA5, 1'b1, 1'b1, 6'd8);
    exp = {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    capture(88, ln, bz);
    err = -1;
    for (int i = 0; i < 88; i++)
      if (err < 0 && (ln[i] !== exp[i/8] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL frame_a5_odd: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/8]);
    end
    tick();
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    exp = {6'b0, 1'b1, 8'h3C, 1'b0};
    capture(40, ln, bz);
    err = -1;
    for (int i = 0; i < 40; i++)
      if (err < 0 && (ln[i] !== exp[i/4] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL frame_3c_nopar: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/4]);
    end
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_3c: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] ln, bz;
    logic [15:0]   exp1, exp2;
    int            err;
    exp1 = {6'b0, 1'b1, 8'h3C, 1'b0};
    exp2 = {6'b0, 1'b1, 8'h01, 1'b0};
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    err = -1;
    for (int i = 0; i < 40; i++) begin
      if (err < 0 && (bus.TX_OUT !== exp1[i/4] || bus.Busy !== 1'b1)) err = i;
      if (i == 39) begin
        bus.P_DATA     = 8'h01;
        bus.Data_Valid = 1'b1;
      end
      tick();
    end
    bus.Data_Valid = 1'b0;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL b2b_first_frame: first bad cycle %0d, required bit %b with Busy 1", err, exp1[err/4]);
    end
    capture(40, ln, bz);
    err = -1;
    for (int i = 0; i < 40; i++)
      if (err < 0 && (ln[i] !== exp2[i/4] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL b2b_second_frame: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp2[err/4]);
    end
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_b2b: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_drop_while_busy();
    logic [15:0] exp;
    int          err;
    exp = {6'b0, 1'b1, 8'h00, 1'b0};
    send(8'h00, 1'b0, 1'b0, 6'd4);
    err = -1;
    for (int i = 0; i < 40; i++) begin
      if (err < 0 && (bus.TX_OUT !== exp[i/4] || bus.Busy !== 1'b1)) err = i;
      bus.Data_Valid = (i == 13);
      bus.P_DATA     = (i == 13) ? 8'hFF : 8'h00;
      // Live config changes mid-frame must not disturb the latched frame.
      if (i == 20) begin
        bus.PAR_EN   = 1'b1;
        bus.Prescale = 6'd9;
      end
      tick();
    end
    bus.Data_Valid = 1'b0;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL drop_frame_unchanged: first bad cycle %0d, required bit %b with Busy 1", err, exp[err/4]);
    end
    err = -1;
    for (int i = 0; i < 12; i++) begin
      if (err < 0 && (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0)) err = i;
      tick();
    end
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL drop_no_extra_frame: non-idle %0d cycles after frame end, required TX_OUT=1 Busy=0", err);
    end
    bus.PAR_EN   = 1'b0;
    bus.Prescale = 6'd4;
  endtask

  task automatic test_reset_mid_frame();
    logic [1023:0] ln, bz;
    logic [15:0]   exp;
    int            err;
    send(8'hA5, 1'b1, 1'b0, 6'd4);
    for (int i = 0; i < 37; i++) tick();
    tests++;
    if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
      failed++;
      $display("FAIL in_parity_before_reset: TX_OUT=%b Busy=%b, required 0 1", bus.TX_OUT, bus.Busy);
    end
    RST = 1'b1;
    #1;
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
    tick();
    RST = 1'b0;
    tick();
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    exp = {6'b0, 1'b1, 8'h3C, 1'b0};
    capture(40, ln, bz);
    err = -1;
    for (int i = 0; i < 40; i++)
      if (err < 0 && (ln[i] !== exp[i/4] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL frame_after_reset: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/4]);
    end
  endtask

  task automatic test_prescale_edges();
    logic [1023:0] ln, bz;
    logic [15:0]   exp;
    logic [5:0]    ps;
    int            err;
    exp = {5'b0, 1'b1, 1'b0, 8'h55, 1'b0};
    for (int k = 0; k < 2; k++) begin
      ps = (k == 0) ? 6'd1 : 6'd0;
      tick();
      send(8'h55, 1'b1, 1'b0, ps);
      capture(11, ln, bz);
      err = -1;
      for (int i = 0; i < 11; i++)
        if (err < 0 && (ln[i] !== exp[i] || bz[i] !== 1'b1)) err = i;
      tests++;
      if (err >= 0) begin
        failed++;
        $display("FAIL prescale_%0d_frame: cycle %0d TX_OUT=%b Busy=%b, required %b 1", ps, err, ln[err], bz[err], exp[err]);
      end
      tests++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
        failed++;
        $display("FAIL prescale_%0d_len: TX_OUT=%b Busy=%b after 11 cycles, required 1 0", ps, bus.TX_OUT, bus.Busy);
      end
    end
    tick();
    send(8'h3C, 1'b0, 1'b0, 6'd32);
    exp = {6'b0, 1'b1, 8'h3C, 1'b0};
    capture(320, ln, bz);
    err = -1;
    for (int i = 0; i < 320; i++)
      if (err < 0 && (ln[i] !== exp[i/32] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL prescale_32_frame: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/32]);
    end
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL prescale_32_len: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
  endtask

`ifdef UART_TX_TWO_STOP_EN
  task automatic test_two_stop();
    logic [1023:0] ln, bz;
    logic [15:0]   exp;
    int            err;
    tick();
    bus.STOP2 = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    bus.STOP2 = 1'b0;
    exp = {5'b0, 2'b11, 8'h3C, 1'b0};
    capture(44, ln, bz);
    err = -1;
    for (int i = 0; i < 44; i++)
      if (err < 0 && (ln[i] !== exp[i/4] || bz[i] !== 1'b1)) err = i;
    tests++;
    if (err >= 0) begin
      failed++;
      $display("FAIL two_stop_frame: cycle %0d TX_OUT=%b Busy=%b, required %b 1", err, ln[err], bz[err], exp[err/4]);
    end
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      failed++;
      $display("FAIL two_stop_len: TX_OUT=%b Busy=%b, required 1 0", bus.TX_OUT, bus.Busy);
    end
  endtask
`endif

  initial begin
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd4;
`ifdef UART_TX_TWO_STOP_EN
    bus.STOP2      = 1'b0;
`endif
    tick();
    test_reset();
    tick();
    test_parity_modes();
    tick();
    test_back_to_back();
    tick();
    test_drop_while_busy();
    tick();
    test_reset_mid_frame();
    test_prescale_edges();
`ifdef UART_TX_TWO_STOP_EN
    test_two_stop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit path of the UART block, counterpart of the RX sampling/deserialising chain.
- Accepts a parallel word with a one-cycle valid strobe and serialises it LSB-first: start bit, data, optional parity, stop.
- Bit period is Prescale cycles of CLK, so TX and RX share one configurable oversampled clock.
- Drives the serial line TX_OUT and a Busy flag back to the system controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9)

Ports:
CLK  input  1  UART oversampling clock
RST  input  1  asynchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel word to send
Data_Valid  input  1  one-cycle strobe; P_DATA is valid this cycle
PAR_EN  input  1  1 = parity bit inserted after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  6  CLK cycles per bit; 0 is treated as 1
TX_OUT  output  1  serial line, registered; idle level 1
Busy  output  1  registered; 1 while a frame is in progress

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, including mid-frame:
  - TX_OUT=1, Busy=0, state=IDLE.
  - Bit counter, cycle counter and the data/config latches are cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept window:
  - state IDLE, or
  - state STOP on the last cycle of the stop bit.
  - Data_Valid outside the accept window is ignored; the word is dropped with no error flag.
- On accept:
  - Latch P_DATA, PAR_EN, PAR_TYP and the bit period max(Prescale,1).
  - The next cycle enters START with TX_OUT=0 and Busy=1.
  - Latency from strobe to start-bit edge is exactly 1 cycle.
- Config changes mid-frame have no effect; latched values govern the whole frame.
- Cycle counter:
  - Counts 0..period-1 within each bit.
  - The state advances when the count is period-1.
  - The counter wraps to 0 on every bit boundary.
- START: TX_OUT=0 for one bit period, then go to DATA.
- DATA:
  - TX_OUT = latched data[bit_idx], starting at bit_idx=0 (LSB first).
  - bit_idx increments at each bit boundary.
  - After bit DATA_WIDTH-1, go to PARITY if PAR_EN=1, otherwise go to STOP.
- PARITY:
  - Even: TX_OUT = XOR-reduce(data).
  - Odd: TX_OUT = XNOR-reduce(data).
  - Parity is computed from the latched data, not from live P_DATA.
- STOP:
  - TX_OUT=1 for one bit period (two with the optional feature).
  - On the final cycle: if Data_Valid=1, accept and go to START with Busy held at 1 (back-to-back, no idle gap). Otherwise go to IDLE; Busy=0 from the next cycle.
- Busy=1 in every non-IDLE state. Busy falls in the same cycle TX_OUT returns to idle.
- Frame length in CLK cycles = period × (1 + DATA_WIDTH + PAR_EN + stop_bits).
- TX_OUT is driven from a flop only, so there is no combinational path from the inputs to the line.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - Adds input STOP2 (1 bit), latched at accept.
  - STOP2=1 sends two stop bit periods.
  - The accept window moves to the last cycle of the second stop bit.
- Undefined:
  - No STOP2 port.
  - Always one stop bit.

Test Plan:
- Reset to idle: RST pulse -> TX_OUT=1, Busy=0. Data_Valid with P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> one cycle later TX_OUT=0 and Busy=1. Line then carries 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit 8 cycles. Busy=0 after 88 cycles.
- Odd parity, no-parity: 0xA5 with PAR_TYP=1 -> parity bit=1. 0x3C with PAR_EN=0, Prescale=4 -> 10 bits (0,0,0,1,1,1,1,0,0,1), 40 cycles, no parity slot.
- Back-to-back: Data_Valid with 0x01 held on the last stop cycle of the previous frame -> next cycle TX_OUT=0, Busy never drops, second frame is bit-exact.
- Drop while busy: Data_Valid with 0xFF mid-DATA of a 0x00 frame -> current frame unchanged (all data bits 0), no extra frame, Busy falls at the expected cycle.
- Reset mid-frame: RST asserted in PARITY -> TX_OUT=1 and Busy=0 without waiting for a CLK edge. A new frame after release starts cleanly.
- Prescale edges: Prescale=1 and Prescale=0 -> one CLK per bit, 0x55 with even parity = 11 cycles. Prescale=32 -> 32 cycles per bit. With UART_TX_TWO_STOP_EN and STOP2=1 -> stop level lasts 2×Prescale cycles.
